instr_fetch_unit: RTL and testbench



---
 rtl/instr_fetch_unit_pkg.sv | 15 +
 rtl/instr_fetch_unit_if.sv | 28 ++
 rtl/instr_fetch_unit_fetch_queue.sv | 80 ++++++++
 rtl/instr_fetch_unit.sv | 81 ++++++++
 tb/tb_instr_fetch_unit.sv | 359 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared constants and helpers for the instruction fetch stage.
package instr_fetch_unit_pkg;

    localparam int N_DEFAULT   = 16;               // instruction width
    localparam int AW_DEFAULT  = 5;                // ROM address width
    localparam int ROM_WORDS   = 1 << AW_DEFAULT;  // ROM size in words
    localparam int ROM_LATENCY = 1;                // cycles from Addr to RomQ
    localparam int PC_START    = 0;                // fetch pointer after reset

    // Circular-buffer index advance; depth need not be a power of two.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned depth);
        return (idx + 1 >= depth) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bundles the ROM-side and core-side signals of the fetch stage.
// master: the fetch unit; slave: the environment (ROM + core).
interface instr_fetch_unit_if
    import instr_fetch_unit_pkg::*;
#(
    parameter int N  = N_DEFAULT,
    parameter int AW = AW_DEFAULT
);
    logic          Run;
    logic [AW-1:0] Addr;
    logic [N-1:0]  RomQ;
    logic [N-1:0]  Instr;
    logic [AW-1:0] InstrPC;
    logic          Valid;
    logic          Take;
    logic          Jump;
    logic [AW-1:0] JumpAddr;

    modport master (
        input  Run, RomQ, Take, Jump, JumpAddr,
        output Addr, Instr, InstrPC, Valid
    );

    modport slave (
        output Run, RomQ, Take, Jump, JumpAddr,
        input  Addr, Instr, InstrPC, Valid
    );
endinterface

// File: rtl/instr_fetch_unit_fetch_queue.sv
// Prefetch queue: DEPTH-entry circular FIFO of {instr, pc}.
// The head is presented from a register so the output holds its last
// value whenever the queue is empty or flushed.
module instr_fetch_unit_fetch_queue
    import instr_fetch_unit_pkg::*;
#(
    parameter int N     = N_DEFAULT,
    parameter int AW    = AW_DEFAULT,
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [N-1:0]  push_instr,
    input  logic [AW-1:0] push_pc,
    output logic [CW-1:0] count,
    output logic [N-1:0]  head_instr,
    output logic [AW-1:0] head_pc,
    output logic          head_valid
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [N-1:0]  instr_mem [DEPTH];
    logic [AW-1:0] pc_mem    [DEPTH];
    logic [IW-1:0] rd_ptr, wr_ptr, rd_next, wr_next;
    logic [CW-1:0] kept;

    assign head_valid = (count != '0);

    // Pointer and occupancy arithmetic for this cycle's pop/push.
    always_comb begin
        rd_next = pop  ? IW'(wrap_inc(32'(rd_ptr), DEPTH)) : rd_ptr;
        wr_next = push ? IW'(wrap_inc(32'(wr_ptr), DEPTH)) : wr_ptr;
        kept    = count - CW'(pop);
    end

    // Entry storage; contents are meaningless until counted in.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr] <= push_instr;
            pc_mem[wr_ptr]    <= push_pc;
        end
    end

    // Read/write pointers and count; flush empties the queue.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_next;
            wr_ptr <= wr_next;
            count  <= kept + CW'(push);
        end
    end

    // Head register: next head is either the surviving entry or the word
    // arriving into an empty queue; otherwise the last value is held.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_instr <= '0;
            head_pc    <= '0;
        end else if (!flush) begin
            if (kept == '0) begin
                if (push) begin
                    head_instr <= push_instr;
                    head_pc    <= push_pc;
                end
            end else begin
                head_instr <= instr_mem[rd_next];
                head_pc    <= pc_mem[rd_next];
            end
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues reads to the synchronous
// ROM, tracks the one outstanding response and queues returned words
// for the core behind a Valid/Take handshake. Jump flushes everything.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int N     = N_DEFAULT,
    parameter int AW    = AW_DEFAULT,
    parameter int DEPTH = 2
) (
    input logic                Clock,
    input logic                Clear,
    instr_fetch_unit_if.master bus
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [AW-1:0] pc;
    logic [AW-1:0] tag;
    logic          inflight;
    logic          pop;
    logic          push;
    logic          issue;
    logic [CW-1:0] count;
    logic [CW:0]   occupancy;
    logic [N-1:0]  head_instr;
    logic [AW-1:0] head_pc;
    logic          head_valid;

    assign pop  = bus.Take & head_valid;
    // A response returning during a Jump belongs to the old stream.
    assign push = inflight & ~bus.Jump;

    // Issue only if a queue slot is guaranteed for the response, counting
    // the word being taken now and the one already in flight.
    always_comb begin
        occupancy = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
        issue     = bus.Run & ~bus.Jump & (occupancy < (CW+1)'(DEPTH));
    end

    // Fetch pointer and in-flight tracking; pointer wraps modulo 2^AW.
    always_ff @(posedge Clock) begin
        if (Clear) begin
            pc       <= AW'(PC_START);
            inflight <= 1'b0;
        end else if (bus.Jump) begin
            pc       <= bus.JumpAddr;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                tag <= pc;
                pc  <= pc + 1'b1;
            end
        end
    end

    instr_fetch_unit_fetch_queue #(
        .N     (N),
        .AW    (AW),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fetch_queue (
        .clk        (Clock),
        .rst        (Clear),
        .push       (push),
        .pop        (pop),
        .flush      (bus.Jump),
        .push_instr (bus.RomQ),
        .push_pc    (tag),
        .count      (count),
        .head_instr (head_instr),
        .head_pc    (head_pc),
        .head_valid (head_valid)
    );

    assign bus.Addr    = pc;
    assign bus.Instr   = head_instr;
    assign bus.InstrPC = head_pc;
    assign bus.Valid   = head_valid;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: a queue-based reference model
// of the fetch rules, a behavioural ROM, directed scenarios and a random run.
module tb_instr_fetch_unit;
    localparam int N     = 16;
    localparam int AW    = 5;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic clear;
    always #5 clk = ~clk;

    instr_fetch_unit_if #(.N(N), .AW(AW)) bus();

    instr_fetch_unit #(.N(N), .AW(AW), .DEPTH(DEPTH)) dut (
        .Clock (clk),
        .Clear (clear),
        .bus   (bus)
    );

    logic [N-1:0] mem [32];
    int checks;
    int failures;

    // Synchronous ROM
    always @(posedge clk) bus.RomQ <= mem[bus.Addr];

    // Reference model: visible queue of {word, pc}, a fetch pointer and at
    // most one outstanding read tagged with its address.
    int           m_pc   = 0;
    bit           m_infl = 0;
    int           m_tag  = 0;
    logic [N-1:0] q_i[$];
    int           q_p[$];
    logic [N-1:0] m_instr = '0;
    int           m_ipc   = 0;

    always @(posedge clk) begin : model
        bit mpop;
        bit missue;
        int occ;
        if (clear) begin
            m_pc = 0; m_infl = 0; q_i.delete(); q_p.delete();
            m_instr = '0; m_ipc = 0;
        end else begin
            mpop   = bus.Take && (q_i.size() > 0);
            occ    = q_i.size() - (mpop ? 1 : 0) + (m_infl ? 1 : 0);
            missue = bus.Run && !bus.Jump && (occ < DEPTH);
            if (bus.Jump) begin
                q_i.delete(); q_p.delete();
                m_infl = 0;
                m_pc   = int'(bus.JumpAddr);
            end else begin
                if (mpop) begin
                    void'(q_i.pop_front());
                    void'(q_p.pop_front());
                end
                if (m_infl) begin
                    q_i.push_back(mem[m_tag]);
                    q_p.push_back(m_tag);
                end
                if (missue) begin
                    m_tag = m_pc;
                    m_pc  = (m_pc + 1) % 32;
                end
                m_infl = missue;
            end
            if (q_i.size() > 0) begin
                m_instr = q_i[0];
                m_ipc   = q_p[0];
            end
        end
    end

    // Overflow watchdog: a push into a full queue that is not being drained.
    always @(posedge clk) begin
        if (!clear && dut.push && !dut.pop && (int'(dut.count) >= DEPTH)) begin
            failures++;
            $display("FAIL overflow: push into full queue count=%0d limit=%0d", dut.count, DEPTH);
        end
    end

    task automatic set_in(input bit run, input bit take, input bit jump, input int jaddr);
        bus.Run = run; bus.Take = take; bus.Jump = jump; bus.JumpAddr = AW'(jaddr);
    endtask

    // Clear for one edge; returns at the negedge of cycle 0.
    task automatic start_fresh();
        clear = 1'b1;
        set_in(0, 0, 0, 0);
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic test_reset();
        clear = 1'b1;
        set_in(1, 1, 1, 7);
        repeat (2) @(negedge clk);
        checks++;
        if (bus.Valid !== 1'b0 || bus.Instr !== 16'h0000 || bus.InstrPC !== 5'd0 || bus.Addr !== 5'd0) begin
            failures++;
            $display("FAIL reset_state got V=%0b I=%h PC=%0d A=%0d exp V=0 I=0000 PC=0 A=0",
                     bus.Valid, bus.Instr, bus.InstrPC, bus.Addr);
        end
        clear = 1'b0;
        set_in(0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (bus.Valid !== (q_i.size() != 0) || bus.Instr !== m_instr || bus.InstrPC !== AW'(m_ipc) || bus.Addr !== AW'(m_pc)) begin
            failures++;
            $display("FAIL reset_idle got V=%0b I=%h PC=%0d A=%0d exp V=%0b I=%h PC=%0d A=%0d",
                     bus.Valid, bus.Instr, bus.InstrPC, bus.Addr, q_i.size() != 0, m_instr, m_ipc, m_pc);
        end
    endtask

    task automatic test_startup();
        start_fresh();
        for (int k = 0; k <= 6; k++) begin
            set_in(1, 0, 0, 0);
            checks++;
            if (bus.Valid !== (q_i.size() != 0) || bus.Instr !== m_instr || bus.InstrPC !== AW'(m_ipc) || bus.Addr !== AW'(m_pc)) begin
                failures++;
                $display("FAIL startup_model k=%0d got V=%0b I=%h PC=%0d A=%0d exp V=%0b I=%h PC=%0d A=%0d",
                         k, bus.Valid, bus.Instr, bus.InstrPC, bus.Addr, q_i.size() != 0, m_instr, m_ipc, m_pc);
            end
            if (k == 2) begin
                checks++;
                if (bus.Valid !== 1'b1 || bus.Instr !== 16'h0100 || bus.InstrPC !== 5'd0) begin
                    failures++;
                    $display("FAIL startup_first k=2 got V=%0b I=%h PC=%0d exp V=1 I=0100 PC=0",
                             bus.Valid, bus.Instr, bus.InstrPC);
                end
            end
            if (k == 6) begin
                checks++;
                if (bus.Addr !== 5'd2 || bus.Valid !== 1'b1 || bus.Instr !== 16'h0100) begin
                    failures++;
                    $display("FAIL startup_stall got A=%0d V=%0b I=%h exp A=2 V=1 I=0100",
                             bus.Addr, bus.Valid, bus.Instr);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_streaming();
        start_fresh();
        for (int k = 0; k <= 40; k++) begin
            set_in(1, k >= 2, 0, 0);
            checks++;
            if (bus.Valid !== (q_i.size() != 0) || bus.Instr !== m_instr || bus.InstrPC !== AW'(m_ipc) || bus.Addr !== AW'(m_pc)) begin
                failures++;
                $display("FAIL stream_model k=%0d got V=%0b I=%h PC=%0d A=%0d exp V=%0b I=%h PC=%0d A=%0d",
                         k, bus.Valid, bus.Instr, bus.InstrPC, bus.Addr, q_i.size() != 0, m_instr, m_ipc, m_pc);
            end
            if (k >= 2) begin
                checks++;
                if (bus.Valid !== 1'b1 || bus.Instr !== N'(16'h0100 + (k - 2) % 32) || bus.InstrPC !== AW'((k - 2) % 32)) begin
                    failures++;
                    $display("FAIL stream_seq k=%0d got V=%0b I=%h PC=%0d exp V=1 I=%h PC=%0d",
                             k, bus.Valid, bus.Instr, bus.InstrPC, 16'h0100 + (k - 2) % 32, (k - 2) % 32);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_jump();
        // Jump together with Take while streaming; head is word 3 at k=5.
        start_fresh();
        for (int k = 0; k <= 12; k++) begin
            set_in(1, (k >= 2) && (k <= 5), k == 5, 20);
            checks++;
            if (bus.Valid !== (q_i.size() != 0) || bus.Instr !== m_instr || bus.InstrPC !== AW'(m_ipc) || bus.Addr !== AW'(m_pc)) begin
                failures++;
                $display("FAIL jump_model k=%0d got V=%0b I=%h PC=%0d A=%0d exp V=%0b I=%h PC=%0d A=%0d",
                         k, bus.Valid, bus.Instr, bus.InstrPC, bus.Addr, q_i.size() != 0, m_instr, m_ipc, m_pc);
            end
            if (k == 6 || k == 7) begin
                checks++;
                if (bus.Valid !== 1'b0) begin
                    failures++;
                    $display("FAIL jump_flush k=%0d got V=%0b exp V=0", k, bus.Valid);
                end
            end
            if (k == 8) begin
                checks++;
                if (bus.Valid !== 1'b1 || bus.Instr !== 16'h0114 || bus.InstrPC !== 5'd20) begin
                    failures++;
                    $display("FAIL jump_target got V=%0b I=%h PC=%0d exp V=1 I=0114 PC=20",
                             bus.Valid, bus.Instr, bus.InstrPC);
                end
            end
            if (k >= 6) begin
                checks++;
                if (bus.Valid === 1'b1 && (bus.InstrPC === 5'd4 || bus.InstrPC === 5'd5)) begin
                    failures++;
                    $display("FAIL jump_stale k=%0d got PC=%0d exp PC not 4 or 5", k, bus.InstrPC);
                end
            end
            @(negedge clk);
        end
        // Jump with a full queue to the top address; fetch wraps 31 -> 0.
        start_fresh();
        for (int k = 0; k <= 10; k++) begin
            set_in(1, 0, k == 4, 31);
            checks++;
            if (bus.Valid !== (q_i.size() != 0) || bus.Instr !== m_instr || bus.InstrPC !== AW'(m_ipc) || bus.Addr !== AW'(m_pc)) begin
                failures++;
                $display("FAIL jump_wrap_model k=%0d got V=%0b I=%h PC=%0d A=%0d exp V=%0b I=%h PC=%0d A=%0d",
                         k, bus.Valid, bus.Instr, bus.InstrPC, bus.Addr, q_i.size() != 0, m_instr, m_ipc, m_pc);
            end
            if (k == 8) begin
                checks++;
                if (bus.Valid !== 1'b1 || bus.Instr !== 16'h011F || bus.InstrPC !== 5'd31 || bus.Addr !== 5'd1) begin
                    failures++;
                    $display("FAIL jump_wrap got V=%0b I=%h PC=%0d A=%0d exp V=1 I=011f PC=31 A=1",
                             bus.Valid, bus.Instr, bus.InstrPC, bus.Addr);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_run_pause();
        int exp_pc = 0;
        start_fresh();
        for (int k = 0; k <= 29; k++) begin
            set_in(!((k >= 6) && (k < 12)), (k >= 2) && !((k >= 8) && (k < 10)), 0, 0);
            checks++;
            if (bus.Valid !== (q_i.size() != 0) || bus.Instr !== m_instr || bus.InstrPC !== AW'(m_ipc) || bus.Addr !== AW'(m_pc)) begin
                failures++;
                $display("FAIL pause_model k=%0d got V=%0b I=%h PC=%0d A=%0d exp V=%0b I=%h PC=%0d A=%0d",
                         k, bus.Valid, bus.Instr, bus.InstrPC, bus.Addr, q_i.size() != 0, m_instr, m_ipc, m_pc);
            end
            if (bus.Valid === 1'b1 && bus.Take === 1'b1) begin
                checks++;
                if (bus.InstrPC !== AW'(exp_pc % 32) || bus.Instr !== N'(16'h0100 + exp_pc % 32)) begin
                    failures++;
                    $display("FAIL pause_seq k=%0d got PC=%0d I=%h exp PC=%0d I=%h",
                             k, bus.InstrPC, bus.Instr, exp_pc % 32, 16'h0100 + exp_pc % 32);
                end
                exp_pc++;
            end
            @(negedge clk);
        end
        checks++;
        if (exp_pc < 15) begin
            failures++;
            $display("FAIL pause_progress got taken=%0d exp at least 15", exp_pc);
        end
    endtask

    task automatic test_spurious_take();
        start_fresh();
        for (int k = 0; k <= 15; k++) begin
            set_in(k >= 4, 1, 0, 0);
            if (k <= 3) begin
                checks++;
                if (bus.Valid !== 1'b0 || bus.Addr !== 5'd0 || bus.Instr !== 16'h0000) begin
                    failures++;
                    $display("FAIL spurious_take k=%0d got V=%0b A=%0d I=%h exp V=0 A=0 I=0000",
                             k, bus.Valid, bus.Addr, bus.Instr);
                end
            end else begin
                checks++;
                if (bus.Valid !== (q_i.size() != 0) || bus.Instr !== m_instr || bus.InstrPC !== AW'(m_ipc) || bus.Addr !== AW'(m_pc)) begin
                    failures++;
                    $display("FAIL take_push_model k=%0d got V=%0b I=%h PC=%0d A=%0d exp V=%0b I=%h PC=%0d A=%0d",
                             k, bus.Valid, bus.Instr, bus.InstrPC, bus.Addr, q_i.size() != 0, m_instr, m_ipc, m_pc);
                end
                if (k >= 6) begin
                    checks++;
                    if (bus.Valid !== 1'b1 || bus.InstrPC !== AW'(k - 6)) begin
                        failures++;
                        $display("FAIL take_push_steady k=%0d got V=%0b PC=%0d exp V=1 PC=%0d",
                                 k, bus.Valid, bus.InstrPC, k - 6);
                    end
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_clear_mid();
        start_fresh();
        for (int k = 0; k <= 10; k++) begin
            clear = (k == 5);
            set_in(1, k == 5, k == 5, 9);
            checks++;
            if (bus.Valid !== (q_i.size() != 0) || bus.Instr !== m_instr || bus.InstrPC !== AW'(m_ipc) || bus.Addr !== AW'(m_pc)) begin
                failures++;
                $display("FAIL clear_model k=%0d got V=%0b I=%h PC=%0d A=%0d exp V=%0b I=%h PC=%0d A=%0d",
                         k, bus.Valid, bus.Instr, bus.InstrPC, bus.Addr, q_i.size() != 0, m_instr, m_ipc, m_pc);
            end
            if (k == 6) begin
                checks++;
                if (bus.Valid !== 1'b0 || bus.Instr !== 16'h0000 || bus.Addr !== 5'd0) begin
                    failures++;
                    $display("FAIL clear_mid got V=%0b I=%h A=%0d exp V=0 I=0000 A=0",
                             bus.Valid, bus.Instr, bus.Addr);
                end
            end
            if (k == 8) begin
                checks++;
                if (bus.Valid !== 1'b1 || bus.Instr !== 16'h0100 || bus.InstrPC !== 5'd0) begin
                    failures++;
                    $display("FAIL clear_restart got V=%0b I=%h PC=%0d exp V=1 I=0100 PC=0",
                             bus.Valid, bus.Instr, bus.InstrPC);
                end
            end
            @(negedge clk);
        end
        clear = 1'b0;
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            clear = 1'b1;
            for (int i = 0; i < 32; i++) mem[i] = N'($urandom);
            start_fresh();
            for (int k = 0; k < 200; k++) begin
                clear = ($urandom_range(0, 63) == 0);
                set_in($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                       $urandom_range(0, 15) == 0, $urandom_range(0, 31));
                checks++;
                if (bus.Valid !== (q_i.size() != 0) || bus.Instr !== m_instr || bus.InstrPC !== AW'(m_ipc) || bus.Addr !== AW'(m_pc)) begin
                    failures++;
                    $display("FAIL random_model r=%0d k=%0d got V=%0b I=%h PC=%0d A=%0d exp V=%0b I=%h PC=%0d A=%0d",
                             r, k, bus.Valid, bus.Instr, bus.InstrPC, bus.Addr, q_i.size() != 0, m_instr, m_ipc, m_pc);
                end
                @(negedge clk);
            end
        end
        clear = 1'b1;
        for (int i = 0; i < 32; i++) mem[i] = N'(16'h0100 + i);
        @(negedge clk);
        clear = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        clear    = 1'b1;
        set_in(0, 0, 0, 0);
        for (int i = 0; i < 32; i++) mem[i] = N'(16'h0100 + i);
        @(negedge clk);
        test_reset();
        test_startup();
        test_streaming();
        test_jump();
        test_run_pause();
        test_spurious_take();
        test_clear_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
